// File: rtl/bm_dag4_pipe_param_if.sv
// Handshake and operand/result bundle for bm_dag4_pipe_param.
// The master side drives operands and out_ready. The slave side is the pipeline.
interface bm_dag4_pipe_param_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] d_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             acc_clear;
    logic [WIDTH+7:0] acc_out;

    modport master (
        output in_valid, a_in, b_in, c_in, d_in, out_ready, acc_clear,
        input  in_ready, out_valid, out0, out1, acc_out
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, d_in, out_ready, acc_clear,
        output in_ready, out_valid, out0, out1, acc_out
    );
endinterface

// File: rtl/bm_dag4_pipe_param.sv
// Pipelined four-leaf add/sub DAG with a valid/ready handshake and a full-pipeline stall.
// The optional running accumulator on out0 is built only when BM_DAG_ACCUM_EN is defined.
module bm_dag4_pipe_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic                 clock,
    input logic                 reset,
    bm_dag4_pipe_param_if.slave bus
);
    logic             en;
    logic             accept;
    logic             out_valid_q;
    logic [WIDTH-1:0] out0_q;
    logic [WIDTH-1:0] out1_q;
    logic [WIDTH-1:0] leaf_x;
    logic [WIDTH-1:0] leaf_y;
    logic [WIDTH-1:0] leaf_z;
    logic [WIDTH-1:0] leaf_w;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !reset && en;
    assign accept       = bus.in_valid && bus.in_ready;

    assign leaf_x = bus.a_in + bus.b_in;
    assign leaf_y = bus.a_in - bus.b_in;
    assign leaf_z = bus.c_in - bus.d_in;
    assign leaf_w = bus.c_in + bus.d_in;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_valid_q <= 1'b0;
                    out0_q      <= '0;
                    out1_q      <= '0;
                end else if (en) begin
                    out_valid_q <= accept;
                    if (accept) begin
                        out0_q <= leaf_x + leaf_z;
                        out1_q <= leaf_y - leaf_w;
                    end
                end
            end
        end else begin : g_multi
            localparam int LAST = DEPTH - 2;

            logic             stage_valid [DEPTH-1];
            logic [WIDTH-1:0] x_q         [DEPTH-1];
            logic [WIDTH-1:0] y_q         [DEPTH-1];
            logic [WIDTH-1:0] z_q         [DEPTH-1];
            logic [WIDTH-1:0] w_q         [DEPTH-1];

            // Data registers only load behind a valid bit, so bubbles never
            // disturb the held output values.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        stage_valid[i] <= 1'b0;
                        x_q[i]         <= '0;
                        y_q[i]         <= '0;
                        z_q[i]         <= '0;
                        w_q[i]         <= '0;
                    end
                    out_valid_q <= 1'b0;
                    out0_q      <= '0;
                    out1_q      <= '0;
                end else if (en) begin
                    stage_valid[0] <= accept;
                    if (accept) begin
                        x_q[0] <= leaf_x;
                        y_q[0] <= leaf_y;
                        z_q[0] <= leaf_z;
                        w_q[0] <= leaf_w;
                    end
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        stage_valid[i] <= stage_valid[i-1];
                        if (stage_valid[i-1]) begin
                            x_q[i] <= x_q[i-1];
                            y_q[i] <= y_q[i-1];
                            z_q[i] <= z_q[i-1];
                            w_q[i] <= w_q[i-1];
                        end
                    end
                    out_valid_q <= stage_valid[LAST];
                    if (stage_valid[LAST]) begin
                        out0_q <= x_q[LAST] + z_q[LAST];
                        out1_q <= y_q[LAST] - w_q[LAST];
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = out_valid_q;
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;

`ifdef BM_DAG_ACCUM_EN
    logic [WIDTH+7:0] acc_q;

    // A clear wins over a transfer on the same edge; that transfer is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (bus.acc_clear) begin
            acc_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            acc_q <= acc_q + {8'd0, out0_q};
        end
    end

    assign bus.acc_out = acc_q;
`else
    logic acc_clear_unused;

    assign acc_clear_unused = bus.acc_clear;
    assign bus.acc_out      = '0;
`endif
endmodule

// File: tb/tb_bm_dag4_pipe_param.sv
// Scoreboard bench for bm_dag4_pipe_param: three instances (8/2, 8/1, 3/8) share one
// stimulus stream; each has its own reference queue predicting timing and results.
module tb_bm_dag4_pipe_param;
    localparam int NDUT = 3;
    localparam int QSZ  = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       acc_clear = 1'b0;
    logic [7:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;

    always #5 clock = ~clock;

    bm_dag4_pipe_param_if #(.WIDTH(8)) if_a ();
    bm_dag4_pipe_param_if #(.WIDTH(8)) if_b ();
    bm_dag4_pipe_param_if #(.WIDTH(3)) if_c ();

    assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;  assign if_c.in_valid = in_valid;
    assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready; assign if_c.out_ready = out_ready;
    assign if_a.acc_clear = acc_clear; assign if_b.acc_clear = acc_clear; assign if_c.acc_clear = acc_clear;
    assign if_a.a_in = a_in; assign if_a.b_in = b_in; assign if_a.c_in = c_in; assign if_a.d_in = d_in;
    assign if_b.a_in = a_in; assign if_b.b_in = b_in; assign if_b.c_in = c_in; assign if_b.d_in = d_in;
    assign if_c.a_in = a_in[2:0]; assign if_c.b_in = b_in[2:0];
    assign if_c.c_in = c_in[2:0]; assign if_c.d_in = d_in[2:0];

    bm_dag4_pipe_param #(.WIDTH(8), .DEPTH(2)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
    bm_dag4_pipe_param #(.WIDTH(8), .DEPTH(1)) dut_b (.clock(clock), .reset(reset), .bus(if_b));
    bm_dag4_pipe_param #(.WIDTH(3), .DEPTH(8)) dut_c (.clock(clock), .reset(reset), .bus(if_c));

    logic [63:0] ov_s [NDUT];
    logic [63:0] ir_s [NDUT];
    logic [63:0] o0_s [NDUT];
    logic [63:0] o1_s [NDUT];
    logic [63:0] acc_s[NDUT];
    assign ov_s[0] = 64'(if_a.out_valid); assign ov_s[1] = 64'(if_b.out_valid); assign ov_s[2] = 64'(if_c.out_valid);
    assign ir_s[0] = 64'(if_a.in_ready);  assign ir_s[1] = 64'(if_b.in_ready);  assign ir_s[2] = 64'(if_c.in_ready);
    assign o0_s[0] = 64'(if_a.out0); assign o0_s[1] = 64'(if_b.out0); assign o0_s[2] = 64'(if_c.out0);
    assign o1_s[0] = 64'(if_a.out1); assign o1_s[1] = 64'(if_b.out1); assign o1_s[2] = 64'(if_c.out1);
    assign acc_s[0] = 64'(if_a.acc_out); assign acc_s[1] = 64'(if_b.acc_out); assign acc_s[2] = 64'(if_c.acc_out);

    typedef struct {
        logic [63:0] o0;
        logic [63:0] o1;
        int          rem;
    } exp_t;

    exp_t        fifo [NDUT][QSZ];
    int          hd [NDUT];
    int          tl [NDUT];
    logic [63:0] acc_exp [NDUT];
    bit          issue_ok [NDUT];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int wid(int k);
        return (k == 2) ? 3 : 8;
    endfunction

    function automatic int dep(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
    endfunction

    // Whole-expression reference: out0 = a+b+c-d, out1 = a-b-c-d, modulo 2^w.
    function automatic logic [63:0] ref0(int w, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        longint s;
        s = longint'(a) + longint'(b) + longint'(c) - longint'(d);
        return 64'(s) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ref1(int w, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        longint s;
        s = longint'(a) - longint'(b) - longint'(c) - longint'(d);
        return 64'(s) & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NDUT; k++)
            if (hd[k] != tl[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Issue side: an accepted input is pushed with the number of enabled edges it still needs.
    initial begin
        forever begin
            @(posedge clock);
            for (int k = 0; k < NDUT; k++) begin
                if (!reset && in_valid && issue_ok[k]) begin
                    fifo[k][tl[k]].o0  = ref0(wid(k), a_in, b_in, c_in, d_in);
                    fifo[k][tl[k]].o1  = ref1(wid(k), a_in, b_in, c_in, d_in);
                    fifo[k][tl[k]].rem = dep(k) - 1;
                    tl[k] = (tl[k] + 1) % QSZ;
                end
            end
        end
    end

    // Monitor: compares mid-cycle, then applies the effect of the coming edge to the model.
    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < NDUT; k++) begin
                string tag;
                bit    eov;
                bit    en;
                exp_t  fr;
                tag = $sformatf("dut%0d", k);
                if (reset) begin
                    chk({tag, ".rst_out_valid"}, ov_s[k], 64'd0);
                    chk({tag, ".rst_in_ready"}, ir_s[k], 64'd0);
                    chk({tag, ".rst_out0"}, o0_s[k], 64'd0);
                    chk({tag, ".rst_out1"}, o1_s[k], 64'd0);
                    chk({tag, ".rst_acc"}, acc_s[k], 64'd0);
                    hd[k] = 0;
                    tl[k] = 0;
                    acc_exp[k] = '0;
                    issue_ok[k] = 1'b0;
                end else begin
                    eov = (hd[k] != tl[k]) && (fifo[k][hd[k]].rem == 0);
                    fr  = fifo[k][hd[k]];
                    chk({tag, ".out_valid"}, ov_s[k], 64'(eov));
                    chk({tag, ".in_ready"}, ir_s[k], 64'(!eov || out_ready));
                    if (eov) begin
                        chk({tag, ".out0"}, o0_s[k], fr.o0);
                        chk({tag, ".out1"}, o1_s[k], fr.o1);
                    end
`ifdef BM_DAG_ACCUM_EN
                    chk({tag, ".acc"}, acc_s[k], acc_exp[k]);
                    if (acc_clear)
                        acc_exp[k] = '0;
                    else if (eov && out_ready)
                        acc_exp[k] = (acc_exp[k] + fr.o0) & ((64'd1 << (wid(k) + 8)) - 64'd1);
`else
                    chk({tag, ".acc"}, acc_s[k], 64'd0);
`endif
                    en = !eov || out_ready;
                    if (en) begin
                        if (eov) hd[k] = (hd[k] + 1) % QSZ;
                        for (int j = hd[k]; j != tl[k]; j = (j + 1) % QSZ)
                            if (fifo[k][j].rem > 0) fifo[k][j].rem--;
                    end
                    issue_ok[k] = en;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        a_in = a; b_in = b; c_in = c; d_in = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Holds one input until the 8/2 instance takes it.
    task automatic send_hold(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        bit ok;
        ok = 1'b0;
        a_in = a; b_in = b; c_in = c; d_in = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            ok = if_a.in_ready;
            @(posedge clock);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_hold_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (all_empty()) break;
            step();
        end
        chk("drain_empty", 64'(all_empty()), 64'd1);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();

        apply(8'd5, 8'd3, 8'd10, 8'd4);
        step();
        chk("basic_out_valid", 64'(if_a.out_valid), 64'd1);
        chk("basic_out0", 64'(if_a.out0), 64'd14);
        chk("basic_out1", 64'(if_a.out1), 64'd244);
        apply(8'd200, 8'd100, 8'd0, 8'd1);
        apply(8'd255, 8'd255, 8'd255, 8'd255);
        drain();
`ifdef BM_DAG_ACCUM_EN
        chk("acc_sum", 64'(if_a.acc_out), 64'd311);
`endif
        acc_clear = 1'b1;
        apply(8'd9, 8'd9, 8'd9, 8'd9);
        drain();
        acc_clear = 1'b0;
        chk("acc_cleared", 64'(if_a.acc_out), 64'd0);

        apply(8'd7, 8'd1, 8'd0, 8'd0);
        chk("d1_same_edge_valid", 64'(if_b.out_valid), 64'd1);
        chk("d1_out0", 64'(if_b.out0), 64'd8);
        lat = 1;
        while (!if_c.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("d8_latency", 64'(lat), 64'd8);
        chk("d8_out0", 64'(if_c.out0), 64'd0);
        chk("d8_out1", 64'(if_c.out1), 64'd6);
        drain();

        fork
            begin
                for (int i = 0; i < 4; i++)
                    send_hold(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            begin
                for (int i = 0; i < 20 && !if_a.out_valid; i++) step();
                out_ready = 1'b0;
                #1;
                chk("stall_in_ready", 64'(if_a.in_ready), 64'd0);
                repeat (3) step();
                out_ready = 1'b1;
            end
        join
        drain();

        apply(8'd1, 8'd2, 8'd3, 8'd4);
        apply(8'd5, 8'd6, 8'd7, 8'd8);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(if_a.out_valid), 64'd0);
        chk("midrst_out0", 64'(if_a.out0), 64'd0);
        chk("midrst_out1", 64'(if_a.out1), 64'd0);
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("post_rst_no_stale", 64'(if_a.out_valid), 64'd0);

        for (int i = 0; i < 400; i++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            c_in = 8'($urandom);
            d_in = 8'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            acc_clear = ($urandom_range(19) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        acc_clear = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
